// File: rtl/fifo_bank_l2.sv
// fifo_bank_l2: four independent 4-deep lane FIFOs (D,E,F,G) with status flags and pause; FIFO_ERROR_FLAG_EN adds sticky error flags
module fifo_bank_l2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int ALMOST_FULL = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_WIDTH-1:0] in_D,
  input  logic [DATA_WIDTH-1:0] in_E,
  input  logic [DATA_WIDTH-1:0] in_F,
  input  logic [DATA_WIDTH-1:0] in_G,
  input  logic validIn_D,
  input  logic validIn_E,
  input  logic validIn_F,
  input  logic validIn_G,
  input  logic pop_D,
  input  logic pop_E,
  input  logic pop_F,
  input  logic pop_G,
  output logic [DATA_WIDTH-1:0] out_D,
  output logic [DATA_WIDTH-1:0] out_E,
  output logic [DATA_WIDTH-1:0] out_F,
  output logic [DATA_WIDTH-1:0] out_G,
  output logic validOut_D,
  output logic validOut_E,
  output logic validOut_F,
  output logic validOut_G,
  output logic [3:0] full,
  output logic [3:0] empty,
  output logic [3:0] almost_full,
  output logic [3:0] almost_empty,
`ifdef FIFO_ERROR_FLAG_EN
  output logic [3:0] error,
`endif
  output logic pause
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(ALMOST_EMPTY);
  logic [3:0][DATA_WIDTH-1:0] din, dout;
  logic [3:0] vin, pop, vout;
  assign din = {in_G, in_F, in_E, in_D};
  assign vin = {validIn_G, validIn_F, validIn_E, validIn_D};
  assign pop = {pop_G, pop_F, pop_E, pop_D};
  assign {out_G, out_F, out_E, out_D} = dout;
  assign {validOut_G, validOut_F, validOut_E, validOut_D} = vout;
  assign pause = |almost_full;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] out_r;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] count;
    logic do_pop, do_push, v_r;
    assign do_pop = pop[i] && count != '0;
    assign do_push = vin[i] && (count != FULL_CNT || do_pop);
    assign dout[i] = out_r;
    assign vout[i] = v_r;
    assign full[i] = count == FULL_CNT;
    assign empty[i] = count == '0;
    assign almost_full[i] = count >= AF_CNT;
    assign almost_empty[i] = count <= AE_CNT;
    // lane storage, pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        out_r <= '0;
        v_r <= 1'b0;
      end else begin
        v_r <= do_pop;
        if (do_pop) begin
          out_r <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push) begin
          mem[wr_ptr] <= din[i];
          wr_ptr <= wr_ptr + 1'b1;
        end
        count <= count + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
      end
    end
`ifdef FIFO_ERROR_FLAG_EN
    logic err;
    assign error[i] = err;
    // sticky flag for a dropped push or an ignored pop
    always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else if ((vin[i] && !do_push) || (pop[i] && count == '0)) err <= 1'b1;
    end
`endif
  end
endmodule
